// File: rtl/result_writeback_if.sv
// Result stream (producer -> writeback) and output-memory write bus (writeback -> memory).
interface result_writeback_if #(
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADR_W  = 8
) ();
    logic                    res_valid;
    logic [ACC_W-1:0]        res_data;
    logic                    res_last;
    logic                    res_ready;
    logic                    mem_req;
    logic [ADR_W-1:0]        mem_adr;
    logic [LANES*DATA_W-1:0] mem_wdata;
    logic [LANES-1:0]        mem_be;
    logic                    mem_ack;

    modport master (
        output res_valid, res_data, res_last, mem_ack,
        input  res_ready, mem_req, mem_adr, mem_wdata, mem_be
    );

    modport slave (
        input  res_valid, res_data, res_last, mem_ack,
        output res_ready, mem_req, mem_adr, mem_wdata, mem_be
    );
endinterface

// File: rtl/result_writeback.sv
// Saturates accumulator results, packs LANES per word, buffers two words and writes
// them to consecutive output-memory addresses; pulses o_done after the last word is acked.
module result_writeback #(
    parameter int unsigned ACC_W     = 20,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned ADR_W     = 8,
    parameter int unsigned NUM_WORDS = 43
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [ADR_W-1:0]    i_base_adr,
    result_writeback_if.slave   bus,
    output logic [ADR_W-1:0]    o_word_cnt,
    output logic                o_done,
    output logic                o_frame_err
);
    localparam int unsigned WORD_W = LANES * DATA_W;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t              r_state;
    logic                r_closed;
    logic [LANE_W-1:0]   r_lane;
    logic [WORD_W-1:0]   r_pack_data;
    logic [LANES-1:0]    r_pack_be;
    logic [WORD_W-1:0]   r_q_data [2];
    logic [LANES-1:0]    r_q_be   [2];
    logic                r_q_last [2];
    logic [1:0]          r_count;
    logic [ADR_W-1:0]    r_base;
    logic [ADR_W-1:0]    r_word_cnt;
    logic                r_res_ready;
    logic                r_mem_req;
    logic [ADR_W-1:0]    r_mem_adr;
    logic                r_done;
    logic                r_frame_err;

    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_sat;
    logic [WORD_W-1:0]   w_pack_data;
    logic [LANES-1:0]    w_pack_be;
    logic                w_xfer;
    logic                w_push;
    logic                w_pop;
    logic                w_start;
    logic                w_last_ack;
    logic                w_closed_nxt;
    logic [1:0]          w_count_nxt;
    logic [ADR_W-1:0]    w_base_nxt;
    logic [ADR_W-1:0]    w_wc_nxt;

    assign w_start      = i_start && (r_state == S_IDLE);
    assign w_xfer       = bus.res_valid && r_res_ready;
    assign w_pop        = r_mem_req && bus.mem_ack;
    assign w_push       = w_xfer && ((r_lane == LANE_W'(LANES - 1)) || bus.res_last);
    assign w_last_ack   = w_pop && r_q_last[0];
    assign w_closed_nxt = w_start ? 1'b0 : ((w_xfer && bus.res_last) ? 1'b1 : r_closed);
    assign w_count_nxt  = w_start ? 2'd0 : (r_count + 2'(w_push) - 2'(w_pop));
    assign w_base_nxt   = w_start ? i_base_adr : r_base;
    assign w_wc_nxt     = w_start ? '0 : (r_word_cnt + ADR_W'(w_pop));

    // Clamp to the signed DATA_W range; in-range values are simply truncated
    always_comb begin
        w_sat = bus.res_data[DATA_W-1:0];
        if ($signed(bus.res_data) > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if ($signed(bus.res_data) < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    always_comb begin
        w_pack_data = r_pack_data;
        w_pack_be   = r_pack_be;
        w_pack_data[r_lane*DATA_W +: DATA_W] = w_sat;
        w_pack_be[r_lane] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last_ack) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they always match the current state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_closed    <= 1'b0;
            r_lane      <= '0;
            r_pack_data <= '0;
            r_pack_be   <= '0;
            r_q_data[0] <= '0;
            r_q_data[1] <= '0;
            r_q_be[0]   <= '0;
            r_q_be[1]   <= '0;
            r_q_last[0] <= 1'b0;
            r_q_last[1] <= 1'b0;
            r_count     <= '0;
            r_base      <= '0;
            r_word_cnt  <= '0;
            r_res_ready <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_adr   <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_closed    <= w_closed_nxt;
            r_count     <= w_count_nxt;
            r_base      <= w_base_nxt;
            r_word_cnt  <= w_wc_nxt;
            r_res_ready <= (w_state_nxt == S_RUN) && !w_closed_nxt && (w_count_nxt != 2'd2);
            r_mem_req   <= (w_count_nxt != 2'd0);
            r_mem_adr   <= w_base_nxt + w_wc_nxt;
            r_done      <= (w_state_nxt == S_FIN);

            if (w_start) begin
                r_frame_err <= 1'b0;
            end else if ((w_last_ack && (r_word_cnt != ADR_W'(NUM_WORDS - 1))) ||
                         (bus.res_valid && r_closed)) begin
                r_frame_err <= 1'b1;
            end

            if (w_start || w_push) begin
                r_lane      <= '0;
                r_pack_data <= '0;
                r_pack_be   <= '0;
            end else if (w_xfer) begin
                r_lane      <= r_lane + LANE_W'(1);
                r_pack_data <= w_pack_data;
                r_pack_be   <= w_pack_be;
            end

            // Slot 0 is always the head; slot 1 is kept zero unless two words are held
            if (w_start) begin
                r_q_data[0] <= '0;
                r_q_data[1] <= '0;
                r_q_be[0]   <= '0;
                r_q_be[1]   <= '0;
                r_q_last[0] <= 1'b0;
                r_q_last[1] <= 1'b0;
            end else begin
                unique case ({w_push, w_pop})
                    2'b10: begin
                        if (r_count == 2'd0) begin
                            r_q_data[0] <= w_pack_data;
                            r_q_be[0]   <= w_pack_be;
                            r_q_last[0] <= bus.res_last;
                        end else begin
                            r_q_data[1] <= w_pack_data;
                            r_q_be[1]   <= w_pack_be;
                            r_q_last[1] <= bus.res_last;
                        end
                    end
                    2'b01: begin
                        r_q_data[0] <= r_q_data[1];
                        r_q_be[0]   <= r_q_be[1];
                        r_q_last[0] <= r_q_last[1];
                        r_q_data[1] <= '0;
                        r_q_be[1]   <= '0;
                        r_q_last[1] <= 1'b0;
                    end
                    2'b11: begin
                        if (r_count == 2'd1) begin
                            r_q_data[0] <= w_pack_data;
                            r_q_be[0]   <= w_pack_be;
                            r_q_last[0] <= bus.res_last;
                        end else begin
                            r_q_data[0] <= r_q_data[1];
                            r_q_be[0]   <= r_q_be[1];
                            r_q_last[0] <= r_q_last[1];
                            r_q_data[1] <= w_pack_data;
                            r_q_be[1]   <= w_pack_be;
                            r_q_last[1] <= bus.res_last;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.res_ready = r_res_ready;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_adr   = r_mem_adr;
    assign bus.mem_wdata = r_q_data[0];
    assign bus.mem_be    = r_q_be[0];
    assign o_word_cnt    = r_word_cnt;
    assign o_done        = r_done;
    assign o_frame_err   = r_frame_err;
endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: two instances (43-word and 2-word frames) share one driver,
// selected by sel; writes are compared against a frame-level reference model.
module tb_result_writeback;
    localparam int BUDGET = 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        t_start = 1'b0;
    logic        t_valid = 1'b0;
    logic        t_last = 1'b0;
    logic        t_ack = 1'b0;
    logic [7:0]  t_base = '0;
    logic [19:0] t_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    result_writeback_if bus0 ();
    result_writeback_if bus1 ();

    assign bus0.res_valid = t_valid & ~sel;
    assign bus0.res_data  = t_data;
    assign bus0.res_last  = t_last & ~sel;
    assign bus0.mem_ack   = t_ack & ~sel;
    assign bus1.res_valid = t_valid & sel;
    assign bus1.res_data  = t_data;
    assign bus1.res_last  = t_last & sel;
    assign bus1.mem_ack   = t_ack & sel;

    wire       w_start0 = t_start & ~sel;
    wire       w_start1 = t_start & sel;
    wire [7:0] w_wc0, w_wc1;
    wire       w_done0, w_done1, w_err0, w_err1;

    result_writeback #(.NUM_WORDS(43)) dut0 (
        .clk(clk), .rst(rst), .i_start(w_start0), .i_base_adr(t_base), .bus(bus0.slave),
        .o_word_cnt(w_wc0), .o_done(w_done0), .o_frame_err(w_err0));

    result_writeback #(.NUM_WORDS(2)) dut1 (
        .clk(clk), .rst(rst), .i_start(w_start1), .i_base_adr(t_base), .bus(bus1.slave),
        .o_word_cnt(w_wc1), .o_done(w_done1), .o_frame_err(w_err1));

    wire        w_ready = sel ? bus1.res_ready : bus0.res_ready;
    wire        w_req   = sel ? bus1.mem_req   : bus0.mem_req;
    wire [7:0]  w_adr   = sel ? bus1.mem_adr   : bus0.mem_adr;
    wire [31:0] w_wdata = sel ? bus1.mem_wdata : bus0.mem_wdata;
    wire [3:0]  w_be    = sel ? bus1.mem_be    : bus0.mem_be;
    wire [7:0]  w_wc    = sel ? w_wc1 : w_wc0;
    wire        w_done  = sel ? w_done1 : w_done0;
    wire        w_err   = sel ? w_err1 : w_err0;

    typedef struct {
        int         acc;
        logic [7:0] lane;
    } sat_vec_t;

    int         res_q[$];
    logic [7:0] e_adr[$];
    logic [31:0] e_data[$];
    logic [3:0] e_be[$];
    logic [7:0] cap_adr[$];
    logic [31:0] cap_data[$];
    logic [3:0] cap_be[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sat8(input int v);
        if (v > 127) return 8'h7F;
        if (v < -128) return 8'h80;
        return 8'(v);
    endfunction

    function automatic int rnd_acc();
        case ($urandom_range(3))
            0: return int'($urandom_range(400)) - 200;
            1: return int'($urandom_range(1048575)) - 524288;
            2: return int'($urandom_range(280)) - 140;
            default: return int'($urandom_range(255)) - 128;
        endcase
    endfunction

    // Expected writes: consecutive groups of four results, address base+k mod 256
    task automatic build_model(input logic [7:0] base);
        int n = res_q.size();
        int nw = (n + 3) / 4;
        logic [31:0] d;
        logic [3:0] be;
        e_adr.delete(); e_data.delete(); e_be.delete();
        for (int k = 0; k < nw; k++) begin
            d = '0;
            be = '0;
            for (int i = 0; i < 4; i++) begin
                if (4 * k + i < n) begin
                    d[i*8 +: 8] = sat8(res_q[4*k+i]);
                    be[i] = 1'b1;
                end
            end
            e_adr.push_back(8'(int'(base) + k));
            e_data.push_back(d);
            e_be.push_back(be);
        end
    endtask

    task automatic run_frame(input logic [7:0] base, input int ack_pct, input int vld_pct,
                             input int hold, input bit exp_err);
        int n = res_q.size();
        int idx = 0, widx = 0, cyc = 0, post = 0, dones = 0;
        bit have_prev = 1'b0;
        logic [43:0] prev = '0;
        build_model(base);
        cap_adr.delete(); cap_data.delete(); cap_be.delete();
        @(posedge clk); #1;
        t_base = base; t_start = 1'b1; t_valid = 1'b0; t_ack = 1'b0;
        @(posedge clk); #1;
        t_start = 1'b0;
        while (post < 4 && cyc < BUDGET) begin
            t_valid = (idx < n) && (int'($urandom_range(99)) < vld_pct);
            t_data  = (idx < n) ? 20'(res_q[idx]) : '0;
            t_last  = (idx == n - 1);
            t_ack   = (cyc >= hold) && (int'($urandom_range(99)) < ack_pct);
            @(negedge clk);
            if (have_prev) begin
                chk("req held until ack", 64'(w_req), 64'd1);
                chk("adr/data/be stable while waiting", 64'({w_adr, w_wdata, w_be}), 64'(prev));
            end
            have_prev = w_req && !t_ack;
            prev = {w_adr, w_wdata, w_be};
            if (w_req && t_ack) begin
                if (widx < e_adr.size()) begin
                    chk($sformatf("word%0d adr", widx), 64'(w_adr), 64'(e_adr[widx]));
                    chk($sformatf("word%0d data", widx), 64'(w_wdata), 64'(e_data[widx]));
                    chk($sformatf("word%0d be", widx), 64'(w_be), 64'(e_be[widx]));
                end
                cap_adr.push_back(w_adr); cap_data.push_back(w_wdata); cap_be.push_back(w_be);
                widx++;
            end
            if (t_valid && w_ready) idx++;
            if (w_done) dones++;
            if (hold > 0 && cyc == hold - 1) begin
                chk("backpressure accepted results", 64'(idx), 64'd8);
                chk("backpressure res_ready", 64'(w_ready), 64'd0);
                chk("backpressure mem_req", 64'(w_req), 64'd1);
                chk("backpressure mem_adr", 64'(w_adr), 64'(base));
                chk("backpressure mem_wdata", 64'(w_wdata), 64'(e_data[0]));
            end
            if (dones > 0) post++;
            @(posedge clk); #1;
            cyc++;
        end
        t_valid = 1'b0; t_ack = 1'b0; t_last = 1'b0;
        chk("frame completed within budget", 64'(post >= 4), 64'd1);
        chk("results accepted", 64'(idx), 64'(n));
        chk("words written", 64'(widx), 64'(e_adr.size()));
        chk("done pulses", 64'(dones), 64'd1);
        chk("frame_err", 64'(w_err), 64'(exp_err));
        chk("word_cnt", 64'(w_wc), 64'(8'(e_adr.size())));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " outputs"}, 64'({w_ready, w_req, w_adr, w_wdata, w_be, w_wc, w_done, w_err}), 64'd0);
    endtask

    initial begin
        sat_vec_t sat_tab[8];
        logic [31:0] w;
        int n;
        sat_tab[0] = '{200, 8'h7F};      sat_tab[1] = '{-300, 8'h80};
        sat_tab[2] = '{127, 8'h7F};      sat_tab[3] = '{-128, 8'h80};
        sat_tab[4] = '{128, 8'h7F};      sat_tab[5] = '{-129, 8'h80};
        sat_tab[6] = '{-1, 8'hFF};       sat_tab[7] = '{-524288, 8'h80};

        // Reset values held in reset and just after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 1'b0; #1 chk_all_zero("in reset dut0");
        sel = 1'b1; #1 chk_all_zero("in reset dut1");
        rst = 1'b1;
        @(negedge clk);
        sel = 1'b0; #1 chk_all_zero("after reset dut0");

        // Full frame, results 1..172, ack always high
        res_q.delete();
        for (int i = 1; i <= 172; i++) res_q.push_back(i);
        run_frame(8'h10, 100, 100, 0, 1'b0);
        if (cap_adr.size() == 43) begin
            chk("first word data", 64'(cap_data[0]), 64'h0403_0201);
            chk("first word be", 64'(cap_be[0]), 64'hF);
            chk("first word adr", 64'(cap_adr[0]), 64'h10);
            chk("last word adr", 64'(cap_adr[42]), 64'h3A);
        end

        // Saturation table on the 2-word instance
        sel = 1'b1;
        res_q.delete();
        for (int i = 0; i < 8; i++) res_q.push_back(sat_tab[i].acc);
        run_frame(8'h40, 70, 80, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i / 4 < cap_data.size()) begin
                w = cap_data[i/4];
                chk($sformatf("saturation %0d", sat_tab[i].acc), 64'(w[(i%4)*8 +: 8]),
                    64'(sat_tab[i].lane));
            end
        end

        // Partial final word, address wrap past 0xFF
        res_q.delete();
        for (int i = 0; i < 6; i++) res_q.push_back(rnd_acc());
        run_frame(8'hFF, 60, 90, 0, 1'b0);
        if (cap_be.size() == 2) chk("partial word be", 64'(cap_be[1]), 64'h3);

        // Backpressure: ack held low for 20 cycles
        sel = 1'b0;
        res_q.delete();
        for (int i = 1; i <= 172; i++) res_q.push_back(i * 3 - 200);
        run_frame(8'h50, 100, 100, 20, 1'b0);

        // Early last on result 4, then results offered after the frame closed
        res_q.delete();
        for (int i = 0; i < 4; i++) res_q.push_back(rnd_acc());
        run_frame(8'h00, 100, 100, 0, 1'b1);
        t_valid = 1'b1; t_data = 20'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("res_ready after close", 64'(w_ready), 64'd0);
            @(posedge clk); #1;
        end
        t_valid = 1'b0;
        @(negedge clk);
        chk("frame_err sticky", 64'(w_err), 64'd1);

        // Randomized frames on both instances
        for (int f = 0; f < 3; f++) begin
            sel = 1'b0;
            res_q.delete();
            n = 169 + int'($urandom_range(3));
            for (int i = 0; i < n; i++) res_q.push_back(rnd_acc());
            run_frame(8'($urandom_range(255)), 20 + int'($urandom_range(80)),
                      30 + int'($urandom_range(70)), 0, 1'b0);
            sel = 1'b1;
            res_q.delete();
            n = 5 + int'($urandom_range(3));
            for (int i = 0; i < n; i++) res_q.push_back(rnd_acc());
            run_frame(8'($urandom_range(255)), 20 + int'($urandom_range(80)),
                      30 + int'($urandom_range(70)), 0, 1'b0);
        end

        // Reset while a write request is outstanding, then restart at a new base
        sel = 1'b0;
        res_q.delete();
        for (int i = 1; i <= 172; i++) res_q.push_back(i);
        @(posedge clk); #1;
        t_base = 8'h20; t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        n = 0;
        for (int c = 0; c < 30 && !w_req; c++) begin
            t_valid = 1'b1; t_data = 20'(res_q[n]); t_ack = 1'b0;
            @(negedge clk);
            if (w_ready) n++;
            @(posedge clk); #1;
        end
        chk("mem_req before reset", 64'(w_req), 64'd1);
        #1 rst = 1'b0;
        #1 chk_all_zero("async reset mid-write");
        t_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_frame(8'h80, 50, 70, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
